// File: rtl/ifetch_prefetch_if.sv
// Read port using the core's rstrb/rbusy protocol.
// The master issues addr/rstrb; the slave answers with rdata once rbusy is low.
interface ifetch_prefetch_if;
  logic [31:0] addr;
  logic        rstrb;
  logic [31:0] rdata;
  logic        rbusy;

  modport master (output addr, output rstrb, input rdata, input rbusy);
  modport slave  (input addr, input rstrb, output rdata, output rbusy);
endinterface

// File: rtl/ifetch_prefetch.sv
// Sequential instruction prefetch queue between the core fetch port and instruction memory.
// Streams consecutive words ahead of the core; any non-sequential fetch flushes and redirects.
module ifetch_prefetch #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  ifetch_prefetch_if.slave  cpu,
  ifetch_prefetch_if.master mem
);
  localparam int            PW   = $clog2(DEPTH);
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

  typedef enum logic       {C_READY, C_WAIT} cstate_t;
  typedef enum logic [1:0] {M_IDLE, M_WAIT, M_DROP} mstate_t;

  cstate_t       r_cstate, w_cstate_nxt;
  mstate_t       r_mstate, w_mstate_nxt;
  logic          r_active;
  logic [29:0]   r_fptr;
  logic [29:0]   r_oaddr;
  logic [29:0]   r_qaddr [DEPTH];
  logic [31:0]   r_qdata [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW:0]   r_count;
  logic [31:0]   r_cpu_rdata;
  logic [31:0]   r_mem_addr;
  logic          r_mem_rstrb;

  logic          w_req, w_resp, w_resp_live;
  logic          w_head_hit, w_wait_hit;
  logic          w_hit, w_join, w_miss;
  logic          w_deliver_mem, w_push, w_issue, w_active_nxt;
  logic [PW:0]   w_count_nxt;
  logic [29:0]   w_fbase;
  logic [PW-1:0] w_tail;
  logic          w_unused_lsb;

  assign w_unused_lsb = ^cpu.addr[1:0];

  // The memory ignores rbusy in the cycle it is strobed, so a response needs rstrb low.
  assign w_req       = cpu.rstrb && (r_cstate == C_READY);
  assign w_resp      = ((r_mstate == M_WAIT) || (r_mstate == M_DROP)) && !r_mem_rstrb && !mem.rbusy;
  assign w_resp_live = w_resp && (r_mstate == M_WAIT);

  assign w_head_hit = (r_count != '0) && (r_qaddr[r_head] == cpu.addr[31:2]);
  assign w_wait_hit = (r_count == '0) && (r_mstate == M_WAIT) && (r_oaddr == cpu.addr[31:2]);
  assign w_hit      = w_req && w_head_hit;
  assign w_join     = w_req && !w_head_hit && w_wait_hit;
  assign w_miss     = w_req && !w_head_hit && !w_wait_hit;

  // A word the core is already waiting for bypasses the queue.
  assign w_deliver_mem = w_resp_live && ((r_cstate == C_WAIT) || w_join);
  assign w_push        = w_resp_live && !w_miss && !w_deliver_mem && ((r_oaddr + 30'd1) == r_fptr);

  assign w_count_nxt  = w_miss ? '0 : (r_count + (PW+1)'(w_push) - (PW+1)'(w_hit));
  assign w_fbase      = w_miss ? cpu.addr[31:2] : r_fptr;
  assign w_active_nxt = r_active || w_req;
  assign w_issue      = ((r_mstate == M_IDLE) || w_resp) && w_active_nxt && (w_count_nxt < FULL);
  assign w_tail       = r_head + r_count[PW-1:0];

  always_comb begin
    w_cstate_nxt = r_cstate;
    w_mstate_nxt = r_mstate;
    if (r_cstate == C_READY) begin
      if (w_miss || (w_join && !w_resp_live)) w_cstate_nxt = C_WAIT;
    end else begin
      if (w_resp_live) w_cstate_nxt = C_READY;
    end
    if (w_issue)                                 w_mstate_nxt = M_WAIT;
    else if (w_resp)                             w_mstate_nxt = M_IDLE;
    else if (w_miss && (r_mstate == M_WAIT))     w_mstate_nxt = M_DROP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cstate    <= C_READY;
      r_mstate    <= M_IDLE;
      r_active    <= 1'b0;
      r_head      <= '0;
      r_count     <= '0;
      r_mem_rstrb <= 1'b0;
      r_mem_addr  <= '0;
      r_cpu_rdata <= '0;
    end else begin
      r_cstate    <= w_cstate_nxt;
      r_mstate    <= w_mstate_nxt;
      r_active    <= w_active_nxt;
      r_count     <= w_count_nxt;
      r_mem_rstrb <= w_issue;
      if (w_hit)          r_head      <= r_head + PW'(1);
      if (w_issue)        r_mem_addr  <= {w_fbase, 2'b00};
      if (w_hit)          r_cpu_rdata <= r_qdata[r_head];
      else if (w_deliver_mem) r_cpu_rdata <= mem.rdata;
    end
  end

  // Queue storage and stream pointers carry no reset; count and state gate their use.
  always_ff @(posedge clk) begin
    r_fptr <= w_issue ? (w_fbase + 30'd1) : w_fbase;
    if (w_issue) r_oaddr <= w_fbase;
    if (w_push) begin
      r_qaddr[w_tail] <= r_oaddr;
      r_qdata[w_tail] <= mem.rdata;
    end
  end

  assign cpu.rdata = r_cpu_rdata;
  assign cpu.rbusy = (r_cstate == C_WAIT);
  assign mem.addr  = r_mem_addr;
  assign mem.rstrb = r_mem_rstrb;
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: behavioural memory with programmable wait states,
// fetch driver with a data scoreboard, a vector table plus hand-written corner sequences.
module tb_ifetch_prefetch;
  logic clk;
  logic rst;

  ifetch_prefetch_if cpu_if();
  ifetch_prefetch_if mem_if();

  ifetch_prefetch #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .cpu (cpu_if),
    .mem (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] sb [$];
  logic [31:0] issued [$];
  int          rstrb_cnt = 0;
  int          mem_lat   = 0;

  logic        s_busy1;
  logic        s_rstrb1;
  logic [31:0] s_maddr1;

  typedef struct {
    logic [31:0] addr;
    int          gap;
    int          lat;
  } vec_t;
  vec_t vecs [12];

  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return w ^ 32'hC0DE_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h, required %h", name, act, exp);
    end
  endtask

  // Memory: a strobe seen in cycle t answers in cycle t+1+mem_lat.
  initial begin
    bit          pend;
    int          pcnt;
    logic [31:0] paddr;
    pend = 0;
    pcnt = 0;
    paddr = '0;
    mem_if.rbusy = 1'b0;
    mem_if.rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (pcnt == 0) begin
          mem_if.rbusy = 1'b0;
          mem_if.rdata = memword(paddr);
          pend = 0;
        end else begin
          pcnt--;
          mem_if.rbusy = 1'b1;
          mem_if.rdata = 32'hBAD0_BAD0;
        end
      end else begin
        mem_if.rbusy = 1'b0;
        mem_if.rdata = 32'hBAD0_BAD0;
      end
      if (mem_if.rstrb === 1'b1) begin
        pend = 1;
        pcnt = mem_lat;
        paddr = mem_if.addr;
        mem_if.rbusy = 1'b1;
        issued.push_back(mem_if.addr);
        rstrb_cnt++;
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input int gap, output int lat);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    cpu_if.addr  = a;
    cpu_if.rstrb = 1'b1;
    sb.push_back(memword(a));
    @(negedge clk);
    cpu_if.rstrb = 1'b0;
    s_busy1  = cpu_if.rbusy;
    s_rstrb1 = mem_if.rstrb;
    s_maddr1 = mem_if.addr;
    lat = 1;
    while (cpu_if.rbusy !== 1'b0 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (cpu_if.rbusy !== 1'b0) begin
      n_chk++;
      n_fail++;
      $display("FAIL fetch_timeout: addr %h still busy after %0d cycles, required delivery", a, lat);
      void'(sb.pop_front());
      lat = -1;
    end else if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty: delivered %h, required a pending expectation", cpu_if.rdata);
    end else begin
      chk($sformatf("data_%h", a), cpu_if.rdata, sb.pop_front());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;

    vecs[0]  = '{32'h0000_0004, 10, 1};
    vecs[1]  = '{32'h0000_0008,  0, 1};
    vecs[2]  = '{32'h0000_000C,  0, 1};
    vecs[3]  = '{32'h0000_0010,  0, 1};
    vecs[4]  = '{32'h0000_0014,  0, 1};
    vecs[5]  = '{32'h0000_0018,  0, 1};
    vecs[6]  = '{32'h0000_0040, 10, 3};
    vecs[7]  = '{32'h0000_0044, 10, 1};
    vecs[8]  = '{32'h0000_004A,  0, 1};
    vecs[9]  = '{32'h0000_004C,  0, 1};
    vecs[10] = '{32'h0000_0080, 10, 3};
    vecs[11] = '{32'h0000_0084, 10, 1};

    cpu_if.addr  = '0;
    cpu_if.rstrb = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_cpu_rdata", cpu_if.rdata, 32'h0);
    chk("reset_cpu_rbusy", 32'(cpu_if.rbusy), 32'h0);
    chk("reset_mem_rstrb", 32'(mem_if.rstrb), 32'h0);
    chk("reset_mem_addr",  mem_if.addr, 32'h0);
    base = rstrb_cnt;
    repeat (6) @(negedge clk);
    chk("idle_no_prefetch", 32'(rstrb_cnt - base), 32'h0);

    // Cold miss with zero-wait memory.
    fetch(32'h0, 0, lat);
    chk("zw_rbusy_t1",   32'(s_busy1), 32'h1);
    chk("zw_rstrb_t1",   32'(s_rstrb1), 32'h1);
    chk("zw_maddr_t1",   s_maddr1, 32'h0);
    chk("zw_latency",    32'(lat), 32'd3);

    for (int i = 0; i < 12; i++) begin
      fetch(vecs[i].addr, vecs[i].gap, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Queue fill with a stalled core, then one hit frees one slot.
    repeat (10) @(negedge clk);
    base = rstrb_cnt;
    fetch(32'h200, 0, lat);
    chk("fill_miss_latency", 32'(lat), 32'd3);
    repeat (20) @(negedge clk);
    chk("fill_pulses", 32'(rstrb_cnt - base), 32'd5);
    base = rstrb_cnt;
    repeat (10) @(negedge clk);
    chk("full_no_pulses", 32'(rstrb_cnt - base), 32'd0);
    fetch(32'h204, 0, lat);
    chk("full_hit_latency", 32'(lat), 32'd1);
    chk("full_hit_rstrb_t1", 32'(s_rstrb1), 32'h1);
    chk("full_hit_maddr_t1", s_maddr1, 32'h214);

    // Address wrap at the top of the space.
    fetch(32'hFFFF_FFF8, 10, lat);
    chk("wrap_miss_latency", 32'(lat), 32'd3);
    fetch(32'hFFFF_FFFC, 10, lat);
    chk("wrap_hit0_latency", 32'(lat), 32'd1);
    fetch(32'h0000_0000, 0, lat);
    chk("wrap_hit1_latency", 32'(lat), 32'd1);
    fetch(32'h0000_0004, 0, lat);
    chk("wrap_hit2_latency", 32'(lat), 32'd1);

    // Branch while a prefetch is outstanding on slow memory.
    mem_lat = 3;
    repeat (10) @(negedge clk);
    issued.delete();
    fetch(32'h300, 0, lat);
    chk("slow_miss_latency", 32'(lat), 32'd6);
    fetch(32'h100, 0, lat);
    chk("branch_rbusy_t1", 32'(s_busy1), 32'h1);
    chk("branch_latency", 32'(lat), 32'd9);
    chk("branch_issue0", (issued.size() > 0) ? issued[0] : 32'hFFFF_FFFF, 32'h300);
    chk("branch_issue1", (issued.size() > 1) ? issued[1] : 32'hFFFF_FFFF, 32'h304);
    chk("branch_issue2", (issued.size() > 2) ? issued[2] : 32'hFFFF_FFFF, 32'h100);
    fetch(32'h104, 10, lat);
    chk("branch_next_hit_latency", 32'(lat), 32'd1);

    // Reset with a fetch pending and memory still busy.
    repeat (30) @(negedge clk);
    @(negedge clk);
    cpu_if.addr  = 32'h500;
    cpu_if.rstrb = 1'b1;
    @(negedge clk);
    cpu_if.rstrb = 1'b0;
    chk("rst_pre_rbusy", 32'(cpu_if.rbusy), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_rbusy", 32'(cpu_if.rbusy), 32'h0);
    chk("rst_mid_rstrb", 32'(mem_if.rstrb), 32'h0);
    chk("rst_mid_rdata", cpu_if.rdata, 32'h0);
    base = rstrb_cnt;
    repeat (12) @(negedge clk);
    chk("rst_no_prefetch", 32'(rstrb_cnt - base), 32'h0);
    mem_lat = 0;
    fetch(32'h500, 0, lat);
    chk("rst_late_not_pushed", 32'(lat), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
